// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   This block shares the single write port of rf_32 between two writeback
//   sources:
//     - primary:   the in-order pipeline writeback.
//     - secondary: a multi-cycle unit, such as mul/div or a load miss.
//   The primary source normally wins. The secondary source is forced through
//   once it has been refused for STARVE_LIMIT consecutive cycles.
//
//   A 32-bit pending-write scoreboard (busy_mask) lets the hazard unit stall
//   readers of registers that still have a secondary write outstanding.
//
// Ports:
//   clock, reset                : rising-edge clock; asynchronous active-high reset
//   pri_valid/ready/addr/data   : primary write request handshake
//   sec_valid/ready/addr/data   : secondary write request handshake
//   rsv_valid, rsv_addr         : reserve a destination for a future secondary write
//   busy_mask                   : bit n set = register n has a pending secondary write
//   write_addr/data/enabled     : registered write port driving rf_32
//
// Optional feature (macro RF_BYPASS_EN):
//   Adds read_addr_s/read_addr_t, rf_outA/rf_outB and read_data_s/read_data_t.
//   These give combinational forwarding of the write being committed this cycle.
//
// Parameters:
//   STARVE_LIMIT : consecutive refusals before the secondary is forced (1..15)
//   CNT_W        : starvation counter width; must be able to hold STARVE_LIMIT
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pri_valid,
  output logic        pri_ready,
  input  logic [4:0]  pri_addr,
  input  logic [31:0] pri_data,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic [4:0]  sec_addr,
  input  logic [31:0] sec_data,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  output logic [31:0] busy_mask,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        write_enabled
`ifdef RF_BYPASS_EN
  ,
  input  logic [4:0]  read_addr_s,
  input  logic [4:0]  read_addr_t,
  input  logic [31:0] rf_outA,
  input  logic [31:0] rf_outB,
  output logic [31:0] read_data_s,
  output logic [31:0] read_data_t
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [31:0]      busy_mask_reg;
  logic [31:0]      busy_mask_next;
  logic [4:0]       write_addr_reg;
  logic [31:0]      write_data_reg;
  logic             write_enabled_reg;

  logic force_sec;
  logic pri_acc;
  logic sec_acc;

  // The secondary has been refused long enough, so it now wins the port.
  assign force_sec = (starve_cnt_reg == LIMIT);

  // The two ready equations are mutually exclusive whenever both requests
  // are valid, so at most one request is accepted per cycle.
  assign pri_ready = !reset && !(force_sec && sec_valid);
  assign sec_ready = !reset && (!pri_valid || force_sec);

  assign pri_acc = pri_valid && pri_ready;
  assign sec_acc = sec_valid && sec_ready;

  // Scoreboard update. The set is applied after the clear, so a reserve
  // wins over a secondary clear of the same register on the same edge.
  always_comb begin
    busy_mask_next = busy_mask_reg;
    if (sec_acc) begin
      busy_mask_next[sec_addr] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      busy_mask_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_reg    <= '0;
      busy_mask_reg     <= '0;
      write_addr_reg    <= '0;
      write_data_reg    <= '0;
      write_enabled_reg <= 1'b0;
    end else begin
      busy_mask_reg <= busy_mask_next;

      // A request accepted for $zero is still consumed, but the write
      // enable stays low so register 0 is never written.
      if (pri_acc) begin
        write_addr_reg    <= pri_addr;
        write_data_reg    <= pri_data;
        write_enabled_reg <= (pri_addr != 5'd0);
      end else if (sec_acc) begin
        write_addr_reg    <= sec_addr;
        write_data_reg    <= sec_data;
        write_enabled_reg <= (sec_addr != 5'd0);
      end else begin
        write_enabled_reg <= 1'b0;
      end

      // The counter only counts while the secondary is waiting and refused.
      // It clears on a grant and whenever the secondary stops requesting.
      if (sec_valid && !sec_ready) begin
        if (starve_cnt_reg != LIMIT) begin
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
      end else begin
        starve_cnt_reg <= '0;
      end
    end
  end

  assign busy_mask     = busy_mask_reg;
  assign write_addr    = write_addr_reg;
  assign write_data    = write_data_reg;
  assign write_enabled = write_enabled_reg;

`ifdef RF_BYPASS_EN
  // Forward the write being committed this cycle. Register 0 never matches,
  // because write_enabled is already low for it.
  assign read_data_s = (write_enabled_reg && (write_addr_reg == read_addr_s))
                       ? write_data_reg : rf_outA;
  assign read_data_t = (write_enabled_reg && (write_addr_reg == read_addr_t))
                       ? write_data_reg : rf_outB;
`endif

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of rf_32 between two writeback sources.
  - Primary: the in-order pipeline writeback.
  - Secondary: a multi-cycle unit such as mul/div or a load miss.
- Keeps a 32-bit pending-write scoreboard so the hazard unit can stall readers of registers with outstanding secondary writes.
- Sits between the writeback stage and the write_addr/write_data/write_enabled inputs of rf_32.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the secondary may be refused before it is forced to win; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pri_valid  input  1  primary write request
- pri_ready  output  1  primary request accepted this cycle when high with pri_valid
- pri_addr  input  5  primary destination register
- pri_data  input  32  primary write data
- sec_valid  input  1  secondary write request
- sec_ready  output  1  secondary request accepted this cycle when high with sec_valid
- sec_addr  input  5  secondary destination register
- sec_data  input  32  secondary write data
- rsv_valid  input  1  reserve a destination for a future secondary write
- rsv_addr  input  5  register to reserve
- busy_mask  output  32  bit n high: register n has an outstanding secondary write
- write_addr  output  5  to rf_32 write_addr
- write_data  output  32  to rf_32 write_data
- write_enabled  output  1  to rf_32 write_enabled

Behaviour:
- Reset: asynchronous and active-high. While reset is high:
  - write_enabled = 0, write_addr = 0, write_data = 0.
  - busy_mask = 0, starvation counter = 0.
  - pri_ready and sec_ready = 0.
  - Reset mid-operation drops all reservations and any request not yet registered.
- force signal: force = (starve_cnt == STARVE_LIMIT).
- Ready equations (combinational):
  - pri_ready = !reset && !(force && sec_valid)
  - sec_ready = !reset && (!pri_valid || force)
  - At most one request is accepted per cycle.
- Acceptance occurs at a rising edge where valid && ready. At that edge the request is registered onto write_addr/write_data.
- write_enabled:
  - Set to 1 for exactly the following cycle when the accepted address is nonzero.
  - Set to 0 when the address is 0; the request is still accepted (MIPS $zero is never written).
  - Is 0 in any cycle with no prior acceptance.
  - Latency is one cycle from acceptance to write_enabled high; rf_32 commits at the next edge.
  - Back-to-back acceptances give continuous write_enabled = 1.
- write_addr/write_data hold their last values when write_enabled = 0.
- Starvation counter:
  - Increments on each edge with sec_valid && !sec_ready, saturating at STARVE_LIMIT.
  - Clears to 0 on secondary acceptance or on any edge with sec_valid = 0.
- Scoreboard:
  - rsv_valid with rsv_addr != 0 sets busy_mask[rsv_addr] at the edge.
  - rsv_addr = 0 is ignored.
  - Secondary acceptance clears busy_mask[sec_addr] at the acceptance edge.
  - Reserve and clear of the same address on the same edge: set wins.
  - Reserving an already-busy register leaves it set.
  - Primary writes never touch busy_mask.
- Primary and secondary targeting the same address in the same cycle: only the granted one is accepted; the other retries later, so rf ordering follows grant order.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined, add these ports:
  - read_addr_s input 5, read_addr_t input 5
  - rf_outA input 32, rf_outB input 32
  - read_data_s output 32, read_data_t output 32
- With the feature:
  - read_data_s = write_data when write_enabled && write_addr == read_addr_s, else rf_outA. The same rule applies to read_data_t with read_addr_t and rf_outB.
  - The bypass is combinational, giving same-cycle forwarding of the write being committed.
  - Address 0 never bypasses, because write_enabled is already 0 for it.
- Without the feature: the ports are absent and no bypass logic exists.

Test Plan:
1. Reset high 20 ns, then pri_valid = 1, pri_addr = 5, pri_data = 32'h11111111 for one cycle -> next cycle write_enabled = 1, write_addr = 5, write_data = 32'h11111111; the cycle after, write_enabled = 0.
2. pri_valid and sec_valid both high continuously, STARVE_LIMIT = 4:
   - sec_ready = 0 for 4 cycles, then sec_ready = 1 and pri_ready = 0 in the 5th cycle.
   - write_addr sequence shows 4 primary writes, then 1 secondary write.
   - Counter returns to 0.
3. rsv_valid with rsv_addr = 9 -> busy_mask = 32'h00000200. Then secondary accepted with sec_addr = 9 -> busy_mask = 0 after that edge. Reserve of 9 on the same edge as its clear -> bit stays 1.
4. pri_addr = 0, pri_data = 32'hDEADBEEF accepted -> pri_ready = 1 but write_enabled stays 0. rsv_addr = 0 -> busy_mask unchanged.
5. Reserve registers 3 and 7, then assert reset for one cycle mid-stream -> busy_mask = 0, write_enabled = 0, counter cleared, all immediately (asynchronous), before the next clock edge.
6. RF_BYPASS_EN: write 32'hCAFEF00D to register 12 with read_addr_s = 12 and rf_outA = 0 -> read_data_s = 32'hCAFEF00D in the write_enabled cycle and 0 (rf_outA) otherwise.
